// File: rtl/mux_adc_serial_tx.sv
// Multiplexed ADC sequencer with serial frame transmitter.
// Scans channels, converts one sample per attempt and shifts it out on data_out.
module mux_adc_serial_tx #(
  parameter int CHANNELS  = 8,
  parameter int DATA_W    = 8,
  parameter int DIV       = 104,
  parameter int PARITY_EN = 0,
  parameter int TIMEOUT   = 1023
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        run,
  input  logic                        eoc,
  input  logic [DATA_W-1:0]           data_in,
  input  logic                        dsr,
  output logic                        soc,
  output logic                        mux_en,
  output logic [$clog2(CHANNELS)-1:0] canale,
  output logic                        load_dato,
  output logic                        data_out,
  output logic                        error,
  output logic                        busy
);

  localparam int CH_W   = $clog2(CHANNELS);
  localparam int NBITS  = DATA_W + 2 + PARITY_EN;
  localparam int BIT_W  = $clog2(NBITS);
  localparam int BAUD_W = $clog2(DIV);
  localparam int TO_W   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUX,
    S_SOC,
    S_WAIT,
    S_LOAD,
    S_TX,
    S_GAP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CH_W-1:0]     r_ch;
  logic [BAUD_W-1:0]   r_baud;
  logic [BIT_W-1:0]    r_bit;
  logic [TO_W-1:0]     r_to;
  logic [DATA_W-1:0]   r_sh;
  logic                r_par;
  logic                r_err;
  logic                w_bdone;
  logic                w_last;
  logic                w_tout;
  logic                w_txbit;

  always_comb begin
    w_next  = r_state;
    w_bdone = (r_baud == BAUD_W'(DIV - 1));
    w_last  = (r_bit == BIT_W'(NBITS - 1));
    w_tout  = (r_to == TO_W'(TIMEOUT - 1));
    case (r_state)
      S_IDLE: if (run) w_next = S_MUX;
      S_MUX:  w_next = S_SOC;
      S_SOC:  w_next = S_WAIT;
      S_WAIT: begin
        if (eoc)         w_next = S_LOAD;
        else if (w_tout) w_next = S_GAP;
      end
      S_LOAD: w_next = dsr ? S_TX : S_GAP;
      S_TX:   if (w_bdone && w_last) w_next = S_GAP;
      S_GAP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Frame: start, data MSB first from the shift register, optional parity, stop.
  always_comb begin
    w_txbit = 1'b1;
    if (r_bit == '0)
      w_txbit = 1'b0;
    else if (r_bit <= BIT_W'(DATA_W))
      w_txbit = r_sh[DATA_W-1];
    else if (PARITY_EN != 0 && r_bit == BIT_W'(DATA_W + 1))
      w_txbit = r_par;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_baud  <= '0;
      r_bit   <= '0;
      r_to    <= '0;
      r_sh    <= '0;
      r_par   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_SOC: r_to <= '0;
        S_WAIT: begin
          if (!eoc) begin
            if (w_tout) r_err <= 1'b1;
            else        r_to  <= r_to + TO_W'(1);
          end
        end
        S_LOAD: begin
          r_sh   <= data_in;
          r_par  <= ^data_in;
          r_baud <= '0;
          r_bit  <= '0;
          r_err  <= ~dsr;
        end
        S_TX: begin
          if (w_bdone) begin
            r_baud <= '0;
            r_bit  <= w_last ? '0 : r_bit + BIT_W'(1);
            if (r_bit != '0 && r_bit <= BIT_W'(DATA_W))
              r_sh <= {r_sh[DATA_W-2:0], 1'b0};
          end else begin
            r_baud <= r_baud + BAUD_W'(1);
          end
        end
        S_GAP: begin
          if (r_ch == CH_W'(CHANNELS - 1)) r_ch <= '0;
          else                             r_ch <= r_ch + CH_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign soc       = (r_state == S_SOC);
  assign mux_en    = (r_state == S_MUX) || (r_state == S_SOC) ||
                     (r_state == S_WAIT);
  assign load_dato = (r_state == S_LOAD);
  assign data_out  = (r_state == S_TX) ? w_txbit : 1'b1;
  assign busy      = (r_state != S_IDLE);
  assign canale    = r_ch;
  assign error     = r_err;

endmodule
